// File: rtl/autotype_seq.sv
// rtl/autotype_seq.sv - scripted key/reset sequencer driving a target computer from a step table
module autotype_seq #(
  parameter int KEYS        = 3,
  parameter int STEPS       = 16,
  parameter int STEP_CYCLES = 8388608,
  parameter logic [STEPS*(KEYS+1)-1:0] SCRIPT = 64'h0004_0004_0402_0108,
  parameter bit AUTOSTART   = 1'b1,
  parameter bit LOOP        = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  output logic            n_reset_out,
  output logic [KEYS-1:0] keys,
  output logic            busy,
  output logic            done
);

  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int EW = KEYS + 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);
  localparam logic [PW-1:0] LAST_CYC  = PW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [EW-1:0]   entry;
  logic            n_reset_d;
  logic [KEYS-1:0] keys_d;
  logic            busy_d;
  logic            done_d;

  assign entry = SCRIPT[int'(step_q)*EW +: EW];

  // Counters stop at their last value before wrapping, so no width overflow is possible.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    presc_d = presc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          step_d  = '0;
          presc_d = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_DONE;
          presc_d = '0;
        end else if (start) begin
          step_d  = '0;
          presc_d = '0;
        end else if (presc_q == LAST_CYC) begin
          presc_d = '0;
          if (step_q == LAST_STEP) begin
            if (LOOP) begin
              step_d = '0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        step_d  = '0;
        presc_d = '0;
      end
    endcase
  end

  always_comb begin
    n_reset_d = 1'b1;
    keys_d    = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_RUN: begin
        n_reset_d = ~entry[KEYS];
        keys_d    = entry[KEYS-1:0];
        busy_d    = 1'b1;
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // Outputs are registered from the current state, giving one cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= AUTOSTART ? S_RUN : S_IDLE;
      step_q      <= '0;
      presc_q     <= '0;
      n_reset_out <= 1'b0;
      keys        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      presc_q     <= presc_d;
      n_reset_out <= n_reset_d;
      keys        <= keys_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_autotype_seq.sv
// tb/tb_autotype_seq.sv - bench for autotype_seq with three parameterisations against a timeline model
module tb_autotype_seq;

  localparam int KEYS  = 2;
  localparam int STEPS = 4;
  localparam int SC    = 4;
  localparam int NDUT  = 3;
  localparam logic [11:0] SCR = 12'b010_000_001_100;
  localparam bit AS [NDUT] = '{1'b1, 1'b1, 1'b0};
  localparam bit LP [NDUT] = '{1'b0, 1'b1, 1'b0};
  localparam bit [2:0] ENT [STEPS] = '{3'b100, 3'b001, 3'b000, 3'b010};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic            nr_o [NDUT];
  logic [KEYS-1:0] k_o  [NDUT];
  logic            b_o  [NDUT];
  logic            d_o  [NDUT];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    autotype_seq #(
      .KEYS(KEYS), .STEPS(STEPS), .STEP_CYCLES(SC), .SCRIPT(SCR),
      .AUTOSTART(AS[g]), .LOOP(LP[g])
    ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .n_reset_out(nr_o[g]), .keys(k_o[g]), .busy(b_o[g]), .done(d_o[g])
    );
  end

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d got=%0d want=%0d at %0t", nm, idx, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 run, 2 done; t counts cycles since the script began.
  int       md [NDUT];
  int       tt [NDUT];
  logic     ex_nr [NDUT];
  logic [1:0] ex_k [NDUT];
  logic     ex_b [NDUT];
  logic     ex_d [NDUT];
  bit       mvalid = 1'b0;

  always @(posedge clk) begin : model
    bit [2:0] e;
    for (int i = 0; i < NDUT; i++) begin
      if (reset) begin
        ex_nr[i] = 1'b0; ex_k[i] = 2'b00; ex_b[i] = 1'b0; ex_d[i] = 1'b0;
        md[i] = AS[i] ? 1 : 0;
        tt[i] = 0;
      end else begin
        if (md[i] == 1) begin
          e = ENT[tt[i] / SC];
          ex_nr[i] = ~e[2]; ex_k[i] = e[1:0]; ex_b[i] = 1'b1; ex_d[i] = 1'b0;
        end else begin
          ex_nr[i] = 1'b1; ex_k[i] = 2'b00; ex_b[i] = 1'b0; ex_d[i] = (md[i] == 2);
        end
        if (md[i] == 1) begin
          if (abort) md[i] = 2;
          else if (start) tt[i] = 0;
          else begin
            tt[i]++;
            if (tt[i] == STEPS * SC) begin
              tt[i] = 0;
              if (!LP[i]) md[i] = 2;
            end
          end
        end else if (start) begin
          md[i] = 1;
          tt[i] = 0;
        end
      end
    end
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int i = 0; i < NDUT; i++) begin
        chk("n_reset_out", i, 8'(nr_o[i]), 8'(ex_nr[i]));
        chk("keys", i, 8'(k_o[i]), 8'(ex_k[i]));
        chk("busy", i, 8'(b_o[i]), 8'(ex_b[i]));
        chk("done", i, 8'(d_o[i]), 8'(ex_d[i]));
      end
    end
  end

  // Kick the script (by start pulse or reset pulse) and check the fixed 16-cycle pattern.
  task automatic play(input int idx, input bit via_start, input bit with_abort);
    logic [1:0] lk;
    logic       lnr;
    if (via_start) begin
      start = 1'b1; abort = with_abort;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
    end else begin
      reset = 1'b1;
      @(negedge clk);
      chk("lit_rst_nr", idx, 8'(nr_o[idx]), 8'd0);
      chk("lit_rst_keys", idx, 8'(k_o[idx]), 8'd0);
      reset = 1'b0;
    end
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      lnr = (c > 4);
      lk  = (c >= 5 && c <= 8) ? 2'b01 : (c >= 13 && c <= 16) ? 2'b10 : 2'b00;
      if (c <= 16) begin
        chk("lit_nr", idx, 8'(nr_o[idx]), 8'(lnr));
        chk("lit_keys", idx, 8'(k_o[idx]), 8'(lk));
        chk("lit_busy", idx, 8'(b_o[idx]), 8'd1);
        if (c == 6) chk("model_keys", idx, 8'(ex_k[idx]), 8'd1);
      end else begin
        chk("lit_end_done", idx, 8'(d_o[idx]), 8'd1);
        chk("lit_end_busy", idx, 8'(b_o[idx]), 8'd0);
        chk("lit_end_nr", idx, 8'(nr_o[idx]), 8'd1);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("lit_reset_busy", 0, 8'(b_o[0]), 8'd0);
    chk("lit_reset_done", 2, 8'(d_o[2]), 8'd0);

    play(0, 1'b0, 1'b0);
    chk("lit_loop_nr", 1, 8'(nr_o[1]), 8'd0);
    chk("lit_loop_busy", 1, 8'(b_o[1]), 8'd1);
    chk("lit_loop_done", 1, 8'(d_o[1]), 8'd0);

    repeat (83) @(negedge clk);
    chk("lit_idle_nr", 2, 8'(nr_o[2]), 8'd1);
    chk("lit_idle_keys", 2, 8'(k_o[2]), 8'd0);
    chk("lit_idle_busy", 2, 8'(b_o[2]), 8'd0);
    play(2, 1'b1, 1'b0);

    pulse_start();
    repeat (5) @(negedge clk);
    chk("lit_pre_abort_keys", 2, 8'(k_o[2]), 8'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk("lit_abort_done", 2, 8'(d_o[2]), 8'd1);
    chk("lit_abort_keys", 2, 8'(k_o[2]), 8'd0);
    play(2, 1'b1, 1'b0);

    pulse_start();
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("lit_pair_run_done", 2, 8'(d_o[2]), 8'd1);
    play(2, 1'b1, 1'b1);

    pulse_start();
    repeat (6) @(negedge clk);
    play(0, 1'b0, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 39) == 0);
      abort = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
